// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants and credit helper for the FIFO drain-side stream reader.
// The optional word counter is enabled by defining FIFO_STREAM_READER_COUNT_EN.
package fifo_stream_reader_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int OUT_SLOTS          = 2;
    // Occupancy holds 0..OUT_SLOTS, so two bits for the 2-slot buffer.
    localparam int OCC_WIDTH          = 2;

    typedef logic [OCC_WIDTH-1:0] occ_t;

    // True while words held plus the one in flight, less this cycle's pop, leave a free slot.
    function automatic logic credit_ok(input occ_t occ, input logic inflight, input logic pop);
        logic [OCC_WIDTH:0] used;
        logic [OCC_WIDTH:0] limit;
        used  = {1'b0, occ} + {{OCC_WIDTH{1'b0}}, inflight};
        limit = (OCC_WIDTH+1)'(OUT_SLOTS) + {{OCC_WIDTH{1'b0}}, pop};
        return used < limit;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_skid.sv
// Two-slot output buffer (module fifo_reader_skid): push at tail, pop at head.
// Clearing resets pointers and occupancy only; stale slot data sits behind occupancy 0.
module fifo_reader_skid
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_clear,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output occ_t                  o_occ,
    output logic [DATA_WIDTH-1:0] o_head_data
);

    logic [DATA_WIDTH-1:0] r_slot [OUT_SLOTS];
    logic                  r_head;
    logic                  r_tail;
    occ_t                  r_occ;

    // Slot storage: written at the tail on every accepted push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot[0] <= '0;
            r_slot[1] <= '0;
        end else if (i_push && !i_clear) begin
            r_slot[r_tail] <= i_push_data;
        end
    end

    // Head/tail pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head <= 1'b0;
            r_tail <= 1'b0;
            r_occ  <= '0;
        end else if (i_clear) begin
            r_head <= 1'b0;
            r_tail <= 1'b0;
            r_occ  <= '0;
        end else begin
            if (i_push) begin
                r_tail <= ~r_tail;
            end
            if (i_pop) begin
                r_head <= ~r_head;
            end
            case ({i_push, i_pop})
                2'b10:   r_occ <= r_occ + occ_t'(1);
                2'b01:   r_occ <= r_occ - occ_t'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_occ       = r_occ;
    assign o_head_data = r_slot[r_head];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-output synchronous FIFO into a valid/ready stream at 1 word/clk.
// Optional: define FIFO_STREAM_READER_COUNT_EN for the word_count output and COUNT_WIDTH parameter.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
`ifdef FIFO_STREAM_READER_COUNT_EN
    ,
    parameter int COUNT_WIDTH = 16
`endif
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   flush,
    output logic                   fifo_rd,
    input  logic [DATA_WIDTH-1:0]  fifo_data,
    input  logic                   fifo_empty,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   idle
`ifdef FIFO_STREAM_READER_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] word_count
`endif
);

    logic                  r_inflight;
    logic                  r_started;
    logic                  w_pop;
    logic                  w_pop_eff;
    logic                  w_push;
    occ_t                  w_occ;
    logic [DATA_WIDTH-1:0] w_head_data;

    assign w_pop     = m_valid && m_ready;
    // A pop coinciding with flush is dropped along with everything else.
    assign w_pop_eff = w_pop && !flush;
    assign w_push    = r_inflight && !flush;

    assign fifo_rd = r_started && enable && !flush && !fifo_empty
                     && credit_ok(w_occ, r_inflight, w_pop);

    assign m_valid = (w_occ != occ_t'(0));
    assign m_data  = w_head_data;
    assign idle    = r_started && (w_occ == occ_t'(0)) && !r_inflight && fifo_empty;

    // In-flight flag tracks the FIFO's one-cycle registered read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_rd;
        end
    end

    // Holds reads and idle low until the first clock after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
        end
    end

    fifo_reader_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_clear     (flush),
        .i_push      (w_push),
        .i_push_data (fifo_data),
        .i_pop       (w_pop_eff),
        .o_occ       (w_occ),
        .o_head_data (w_head_data)
    );

`ifdef FIFO_STREAM_READER_COUNT_EN
    logic [COUNT_WIDTH-1:0] r_word_count;

    // Delivered-word counter; survives flush, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word_count <= '0;
        end else if (w_pop_eff) begin
            r_word_count <= r_word_count + COUNT_WIDTH'(1);
        end
    end

    assign word_count = r_word_count;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized bench for fifo_stream_reader against a queue-based model of words in transit.
// Build with FIFO_STREAM_READER_COUNT_EN defined to also check word_count (COUNT_WIDTH=8).
module tb_fifo_stream_reader;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          flush;
    logic          fifo_rd;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          idle;
`ifdef FIFO_STREAM_READER_COUNT_EN
    logic [7:0]    word_count;
`endif

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_WIDTH (DW)
`ifdef FIFO_STREAM_READER_COUNT_EN
        ,
        .COUNT_WIDTH (8)
`endif
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .flush      (flush),
        .fifo_rd    (fifo_rd),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .idle       (idle)
`ifdef FIFO_STREAM_READER_COUNT_EN
        ,
        .word_count (word_count)
`endif
    );

    typedef struct {
        logic [DW-1:0] d;
        int            rdy;
    } ent_t;

    logic [DW-1:0] fifoq [$];
    ent_t          expq  [$];
    int            cyc;
    bit            started;
    int unsigned   pop_cnt;
    int            checks_total;
    int            checks_passed;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifoq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock: check outputs at negedge against the model, then advance the model after posedge.
    task automatic step();
        logic          e_valid;
        logic          e_pop;
        logic          e_rd;
        logic          e_idle;
        logic [DW-1:0] w;
        int            held;
        @(negedge clk);
        held    = expq.size();
        e_valid = (held > 0) && (expq[0].rdy <= cyc);
        e_pop   = e_valid && m_ready;
        e_rd    = started && enable && !flush && (fifoq.size() > 0)
                  && ((held - (e_pop ? 1 : 0)) < 2);
        e_idle  = started && (held == 0) && (fifoq.size() == 0);
        check_eq("m_valid", 32'(m_valid), 32'(e_valid));
        if (e_valid) begin
            check_eq("m_data", 32'(m_data), 32'(expq[0].d));
        end
        check_eq("fifo_rd", 32'(fifo_rd), 32'(e_rd));
        check_eq("idle", 32'(idle), 32'(e_idle));
`ifdef FIFO_STREAM_READER_COUNT_EN
        check_eq("word_count", 32'(word_count), pop_cnt % 256);
`endif
        @(posedge clk);
        #1;
        cyc++;
        started = 1'b1;
        if (flush) begin
            expq.delete();
        end else if (e_pop) begin
            void'(expq.pop_front());
            pop_cnt++;
        end
        if (e_rd) begin
            w = fifoq.pop_front();
            fifo_data = w;
            expq.push_back('{d: w, rdy: cyc + 1});
        end
        fifo_empty = (fifoq.size() == 0);
    endtask

    // Asserts reset between edges and checks the outputs clear without a clock edge.
    task automatic async_reset();
        reset_n = 1'b0;
        #2;
        check_eq("rst_m_valid", 32'(m_valid), 32'd0);
        check_eq("rst_m_data", 32'(m_data), 32'd0);
        check_eq("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check_eq("rst_idle", 32'(idle), 32'd0);
`ifdef FIFO_STREAM_READER_COUNT_EN
        check_eq("rst_word_count", 32'(word_count), 32'd0);
`endif
        fifoq.delete();
        expq.delete();
        fifo_empty = 1'b1;
        started    = 1'b0;
        pop_cnt    = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] ready_pat;
        checks_total  = 0;
        checks_passed = 0;
        cyc        = 0;
        pop_cnt    = 0;
        started    = 1'b0;
        enable     = 1'b0;
        flush      = 1'b0;
        m_ready    = 1'b0;
        fifo_data  = '0;
        fifo_empty = 1'b1;
        reset_n    = 1'b1;
        #1;
        async_reset();

        // Three preloaded words streamed with the consumer always ready.
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        enable  = 1'b1;
        m_ready = 1'b1;
        repeat (8) step();

        // Sixteen words under a 1,0,0,1 ready pattern with random perturbation.
        ready_pat = 4'b1001;
        for (int i = 0; i < 16; i++) begin
            push_word(8'($urandom));
        end
        for (int i = 0; i < 60; i++) begin
            m_ready = ready_pat[i % 4] ^ ($urandom_range(0, 7) == 0);
            step();
        end
        m_ready = 1'b1;
        repeat (6) step();

        // Back-pressure: five words, consumer stalled, then released.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_word(8'(8'hA0 + i));
        end
        repeat (10) step();
        m_ready = 1'b1;
        repeat (10) step();

        // Flush the cycle after a read is issued.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_word(8'(8'hC0 + i));
        end
        step();
        flush = 1'b1;
        step();
        flush   = 1'b0;
        m_ready = 1'b1;
        repeat (10) step();

        // Buffer full, reads disabled, buffered words still delivered.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_word(8'(8'hE0 + i));
        end
        repeat (4) step();
        enable = 1'b0;
        repeat (3) step();
        m_ready = 1'b1;
        repeat (5) step();
        enable = 1'b1;
        repeat (6) step();

        // Long random run with flushes, enable gaps and back-pressure.
        for (int i = 0; i < 3000 && pop_cnt < 320; i++) begin
            if (fifoq.size() < 3 && $urandom_range(0, 3) != 0) begin
                push_word(8'($urandom));
            end
            enable  = ($urandom_range(0, 7) != 0);
            flush   = ($urandom_range(0, 24) == 0);
            m_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        flush   = 1'b0;
        enable  = 1'b1;
        m_ready = 1'b1;

        // Asynchronous reset in the middle of a transfer, then resume.
        for (int i = 0; i < 4; i++) begin
            push_word(8'($urandom));
        end
        repeat (3) step();
        async_reset();
        push_word(8'h5A);
        push_word(8'hA5);
        push_word(8'h3C);
        repeat (8) step();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
